// File: rtl/bat_ram_arbiter.sv
// bat_ram_arbiter
// Shares one single-port synchronous RAM between the CPU controller and the
// external loader/debug port. Each access takes three cycles (IDLE, ACCESS,
// COMPLETE). HALT blocks new CPU grants so the external port owns memory.
//
// Optional feature macro: BAT_ARB_ROUND_ROBIN_EN
//   defined   : when both ports are eligible, the port not granted last wins
//   undefined : fixed priority CPU > EXT, with EXT forced in once the CPU has
//               been granted STARVE_LIMIT times in a row while EXT waited
//
// state        | meaning
// ST_IDLE      | nothing in flight; requests sampled and winner latched on the edge
// ST_ACCESS    | RAM_EN high for the latched access (only cycle it is high)
// ST_COMPLETE  | winner's ACK high, read data presented on its RDATA

module bat_ram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              HALT,
    input  logic              CPU_REQ,
    input  logic              CPU_RW,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic [DATA_W-1:0] CPU_RDATA,
    output logic              CPU_ACK,
    input  logic              EXT_REQ,
    input  logic              EXT_RAM_RW,
    input  logic [ADDR_W-1:0] EXT_ADDR,
    input  logic [DATA_W-1:0] EXT_WDATA,
    output logic [DATA_W-1:0] EXT_RDATA,
    output logic              EXT_ACK,
    output logic              RAM_EN,
    output logic              RAM_RW,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_RDATA,
    output logic [1:0]        GRANT
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CPU  = 2'b01;
    localparam logic [1:0] GNT_EXT  = 2'b10;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_rw_q, ram_rw_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ext_ack_q, ext_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

    logic cpu_elig;
    logic ext_elig;
    logic pick_cpu;
    logic pick_ext;

`ifdef BAT_ARB_ROUND_ROBIN_EN
    logic last_ext_q, last_ext_d;
`else
    localparam logic [7:0] STARVE_MAX = 8'hFF;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);
    logic [7:0] starve_q, starve_d;
`endif

    // Eligibility and winner selection for the current IDLE sample.
    always_comb begin
        cpu_elig = CPU_REQ & ~HALT;
        ext_elig = EXT_REQ;
`ifdef BAT_ARB_ROUND_ROBIN_EN
        // With both eligible, EXT wins only if the CPU was granted last.
        pick_ext = ext_elig & (~cpu_elig | ~last_ext_q);
`else
        // CPU normally wins; EXT is forced in once the starve count hits the limit.
        pick_ext = ext_elig & (~cpu_elig | (starve_q >= STARVE_LIM));
`endif
        pick_cpu = cpu_elig & ~pick_ext;
    end

`ifdef BAT_ARB_ROUND_ROBIN_EN
    // Remember which port took the most recent grant.
    always_comb begin
        last_ext_d = last_ext_q;
        if (state_q == ST_IDLE) begin
            if (pick_ext) begin
                last_ext_d = 1'b1;
            end else if (pick_cpu) begin
                last_ext_d = 1'b0;
            end
        end
    end

    // Last-grant register; resets to EXT so the CPU wins the first contest.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_ext_q <= 1'b1;
        end else begin
            last_ext_q <= last_ext_d;
        end
    end
`else
    // Starve count only moves on IDLE samples; it saturates rather than wraps.
    always_comb begin
        starve_d = starve_q;
        if (state_q == ST_IDLE) begin
            if (pick_ext || !EXT_REQ) begin
                starve_d = '0;
            end else if (pick_cpu && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + 8'd1;
            end
        end
    end

    // Starve count register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ram_en_d    = 1'b0;
        ram_rw_d    = ram_rw_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_ack_d   = 1'b0;
        ext_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ext_rdata_d = ext_rdata_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = GNT_NONE;
                if (pick_cpu) begin
                    grant_d     = GNT_CPU;
                    ram_en_d    = 1'b1;
                    ram_rw_d    = CPU_RW;
                    ram_addr_d  = CPU_ADDR;
                    ram_wdata_d = CPU_WDATA;
                    state_d     = ST_ACCESS;
                end else if (pick_ext) begin
                    grant_d     = GNT_EXT;
                    ram_en_d    = 1'b1;
                    ram_rw_d    = EXT_RAM_RW;
                    ram_addr_d  = EXT_ADDR;
                    ram_wdata_d = EXT_WDATA;
                    state_d     = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // Writes leave RDATA untouched; only reads capture the RAM bus.
                state_d = ST_COMPLETE;
                if (grant_q == GNT_CPU) begin
                    cpu_ack_d = 1'b1;
                    if (ram_rw_q) begin
                        cpu_rdata_d = RAM_RDATA;
                    end
                end else if (grant_q == GNT_EXT) begin
                    ext_ack_d = 1'b1;
                    if (ram_rw_q) begin
                        ext_rdata_d = RAM_RDATA;
                    end
                end
            end

            ST_COMPLETE: begin
                // No bypass: always pass through IDLE before the next grant.
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    // State and output registers; reset kills any in-flight access at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            grant_q     <= GNT_NONE;
            ram_en_q    <= 1'b0;
            ram_rw_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ext_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ram_en_q    <= ram_en_d;
            ram_rw_q    <= ram_rw_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ext_ack_q   <= ext_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

    assign GRANT     = grant_q;
    assign RAM_EN    = ram_en_q;
    assign RAM_RW    = ram_rw_q;
    assign RAM_ADDR  = ram_addr_q;
    assign RAM_WDATA = ram_wdata_q;
    assign CPU_ACK   = cpu_ack_q;
    assign EXT_ACK   = ext_ack_q;
    assign CPU_RDATA = cpu_rdata_q;
    assign EXT_RDATA = ext_rdata_q;

endmodule

// File: tb/tb_bat_ram_arbiter.sv
// Bench for bat_ram_arbiter: directed scenarios followed by a randomized
// request mix checked against a transaction-level arbitration model.

module tb_bat_ram_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        halt;
    logic        cpu_req, cpu_rw, cpu_ack;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ext_req, ext_rw, ext_ack;
    logic [15:0] ext_addr, ext_wdata, ext_rdata;
    logic        ram_en, ram_rw;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic [1:0]  grant;

    logic [15:0] ram_mem [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic        ram_init;

    int n_assert = 0;
    int n_fail   = 0;

    bat_ram_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .CLK(clk), .RST(rst), .HALT(halt),
        .CPU_REQ(cpu_req), .CPU_RW(cpu_rw), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
        .CPU_RDATA(cpu_rdata), .CPU_ACK(cpu_ack),
        .EXT_REQ(ext_req), .EXT_RAM_RW(ext_rw), .EXT_ADDR(ext_addr), .EXT_WDATA(ext_wdata),
        .EXT_RDATA(ext_rdata), .EXT_ACK(ext_ack),
        .RAM_EN(ram_en), .RAM_RW(ram_rw), .RAM_ADDR(ram_addr), .RAM_WDATA(ram_wdata),
        .RAM_RDATA(ram_rdata), .GRANT(grant)
    );

    always begin
        clk = 1'b0;
        #5;
        clk = 1'b1;
        #5;
    end

    function automatic logic [15:0] init_val(input int a);
        if (a == 16) return 16'hBEEF;
        return 16'(a * 257) ^ 16'h5A5A;
    endfunction

    // RAM model: data visible while the registered address is held
    assign ram_rdata = ram_mem[ram_addr];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 65536; i++) ram_mem[16'(i)] <= init_val(i);
        end else if (ram_en && !ram_rw) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int          k, n_cpu, n_bad;
    logic        exp_ext;
    int          starve;
    logic        last_ext;
    logic        cpu_pend, ext_pend, c_rw, e_rw_p;
    logic [15:0] c_addr, c_wd, e_addr_p, e_wd_p;
    logic        ce, ee, w_cpu, w_ext, x_rw;
    logic [15:0] x_addr, x_wd;

    initial begin
        rst = 1'b1; halt = 1'b0; ram_init = 1'b1;
        cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_rw = 1'b0; ext_addr = '0; ext_wdata = '0;
        for (int i = 0; i < 65536; i++) ref_mem[16'(i)] = init_val(i);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        ram_init = 1'b0;

        // reset state
        check("rst_grant", 32'(grant), 0);
        check("rst_ram_en", 32'(ram_en), 0);
        check("rst_cpu_ack", 32'(cpu_ack), 0);
        check("rst_ext_ack", 32'(ext_ack), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_ext_rdata", 32'(ext_rdata), 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_idle_grant", 32'(grant), 0);

        // CPU read of 0x0010
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0010;
        @(negedge clk);
        check("rd_ram_en", 32'(ram_en), 1);
        check("rd_ram_rw", 32'(ram_rw), 1);
        check("rd_ram_addr", 32'(ram_addr), 32'h0010);
        check("rd_grant", 32'(grant), 1);
        check("rd_ack_early", 32'(cpu_ack), 0);
        @(negedge clk);
        check("rd_cpu_ack", 32'(cpu_ack), 1);
        check("rd_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
        check("rd_ram_en_off", 32'(ram_en), 0);
        check("rd_ext_ack", 32'(ext_ack), 0);
        cpu_req = 1'b0;
        @(negedge clk);
        check("rd_ack_clear", 32'(cpu_ack), 0);
        check("rd_idle_grant", 32'(grant), 0);

        // EXT write 0x1234 to 0x0020
        ext_req = 1'b1; ext_rw = 1'b0; ext_addr = 16'h0020; ext_wdata = 16'h1234;
        @(negedge clk);
        check("wr_ram_en", 32'(ram_en), 1);
        check("wr_ram_rw", 32'(ram_rw), 0);
        check("wr_ram_addr", 32'(ram_addr), 32'h0020);
        check("wr_ram_wdata", 32'(ram_wdata), 32'h1234);
        check("wr_grant", 32'(grant), 2);
        @(negedge clk);
        check("wr_ext_ack", 32'(ext_ack), 1);
        check("wr_cpu_ack", 32'(cpu_ack), 0);
        check("wr_ram_en_off", 32'(ram_en), 0);
        check("wr_ext_rdata_hold", 32'(ext_rdata), 0);
        check("wr_mem", 32'(ram_mem[16'h0020]), 32'h1234);
        ext_req = 1'b0;
        ref_mem[16'h0020] = 16'h1234;
        repeat (3) @(negedge clk);

        // both requesting for 8 accesses
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0010;
        ext_req = 1'b1; ext_rw = 1'b1; ext_addr = 16'h0020;
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            @(negedge clk);
            if (cpu_ack || ext_ack) begin
`ifdef BAT_ARB_ROUND_ROBIN_EN
                exp_ext = (k % 2) == 1;
`else
                exp_ext = (k % (STARVE_LIMIT + 1)) == STARVE_LIMIT;
`endif
                check($sformatf("both_ack_%0d", k), 32'({cpu_ack, ext_ack}), exp_ext ? 1 : 2);
                if (ext_ack) check("both_ext_rdata", 32'(ext_rdata), 32'h1234);
                else         check("both_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
                k++;
                if (k == 8) begin
                    cpu_req = 1'b0;
                    ext_req = 1'b0;
                end
            end
        end
        check("both_count", k, 8);
        cpu_req = 1'b0; ext_req = 1'b0;
        repeat (3) @(negedge clk);

        // HALT with both requesting: EXT only
        halt = 1'b1; cpu_req = 1'b1; ext_req = 1'b1;
        k = 0; n_cpu = 0;
        for (int c = 0; c < 30 && k < 4; c++) begin
            @(negedge clk);
            if (cpu_ack) n_cpu++;
            if (ext_ack) k++;
            if (k == 4) begin
                cpu_req = 1'b0;
                ext_req = 1'b0;
            end
        end
        check("halt_ext_count", k, 4);
        check("halt_cpu_acks", n_cpu, 0);
        cpu_req = 1'b0; ext_req = 1'b0;
        repeat (3) @(negedge clk);
        halt = 1'b0;

        // HALT raised during CPU ACCESS
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0010;
        @(negedge clk);
        check("hia_grant", 32'(grant), 1);
        halt = 1'b1;
        @(negedge clk);
        check("hia_cpu_ack", 32'(cpu_ack), 1);
        check("hia_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        halt = 1'b0;

        // 20 idle cycles
        n_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram_en !== 1'b0 || grant !== 2'b00) n_bad++;
        end
        check("idle_violations", n_bad, 0);

        // CPU_REQ dropped during ACCESS
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0040; cpu_wdata = 16'h5555;
        @(negedge clk);
        check("drp_ram_en", 32'(ram_en), 1);
        cpu_req = 1'b0;
        @(negedge clk);
        check("drp_cpu_ack", 32'(cpu_ack), 1);
        check("drp_mem", 32'(ram_mem[16'h0040]), 32'h5555);
        ref_mem[16'h0040] = 16'h5555;
        n_cpu = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ack) n_cpu++;
        end
        check("drp_extra_acks", n_cpu, 0);

        // reset during ACCESS of a CPU write
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0030; cpu_wdata = 16'hAAAA;
        @(negedge clk);
        check("mr_ram_en", 32'(ram_en), 1);
        rst = 1'b0;
        #1;
        check("mr_ram_en_off", 32'(ram_en), 0);
        check("mr_grant", 32'(grant), 0);
        check("mr_cpu_ack", 32'(cpu_ack), 0);
        check("mr_cpu_rdata", 32'(cpu_rdata), 0);
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mr_mem", 32'(ram_mem[16'h0030]), 32'(ref_mem[16'h0030]));
        rst = 1'b1;
        @(negedge clk);
        check("mr_idle_grant", 32'(grant), 0);
        check("mr_idle_ram_en", 32'(ram_en), 0);

        // randomized mix against the transaction model (state fresh after reset)
        starve = 0; last_ext = 1'b1;
        cpu_pend = 1'b0; ext_pend = 1'b0;
        c_rw = 1'b0; c_addr = '0; c_wd = '0;
        e_rw_p = 1'b0; e_addr_p = '0; e_wd_p = '0;
        for (int r = 0; r < 90; r++) begin
            if (!cpu_pend && $urandom_range(0, 9) < 6) begin
                cpu_pend = 1'b1;
                c_rw   = 1'($urandom);
                c_addr = 16'($urandom_range(0, 15));
                c_wd   = 16'($urandom);
            end
            if (!ext_pend && $urandom_range(0, 9) < 6) begin
                ext_pend = 1'b1;
                e_rw_p   = 1'($urandom);
                e_addr_p = 16'($urandom_range(0, 15));
                e_wd_p   = 16'($urandom);
            end
            halt = ($urandom_range(0, 3) == 0);
            cpu_req = cpu_pend; cpu_rw = c_rw; cpu_addr = c_addr; cpu_wdata = c_wd;
            ext_req = ext_pend; ext_rw = e_rw_p; ext_addr = e_addr_p; ext_wdata = e_wd_p;

            ce = cpu_pend && !halt;
            ee = ext_pend;
            if (ce && ee) begin
`ifdef BAT_ARB_ROUND_ROBIN_EN
                w_ext = !last_ext;
`else
                w_ext = (starve >= STARVE_LIMIT);
`endif
            end else begin
                w_ext = ee;
            end
            w_cpu = ce && !w_ext;
            if (w_ext) begin
                starve = 0; last_ext = 1'b1;
            end else if (w_cpu) begin
                starve = ext_pend ? ((starve < 255) ? starve + 1 : 255) : 0;
                last_ext = 1'b0;
            end else begin
                starve = 0;
            end

            @(negedge clk);
            if (!w_cpu && !w_ext) begin
                check("rnd_idle_grant", 32'(grant), 0);
                check("rnd_idle_en", 32'(ram_en), 0);
                continue;
            end
            x_rw   = w_ext ? e_rw_p : c_rw;
            x_addr = w_ext ? e_addr_p : c_addr;
            x_wd   = w_ext ? e_wd_p : c_wd;
            check($sformatf("rnd_grant_%0d", r), 32'(grant), w_ext ? 2 : 1);
            check("rnd_ram_en", 32'(ram_en), 1);
            check("rnd_ram_addr", 32'(ram_addr), 32'(x_addr));
            check("rnd_ram_rw", 32'(ram_rw), 32'(x_rw));
            if (!x_rw) check("rnd_ram_wdata", 32'(ram_wdata), 32'(x_wd));
            halt = 1'($urandom);
            @(negedge clk);
            check($sformatf("rnd_ack_%0d", r), 32'({cpu_ack, ext_ack}), w_ext ? 1 : 2);
            if (x_rw) check($sformatf("rnd_rdata_%0d", r), 32'(w_ext ? ext_rdata : cpu_rdata),
                            32'(ref_mem[x_addr]));
            else ref_mem[x_addr] = x_wd;
            if (w_ext) begin
                ext_pend = 1'b0; ext_req = 1'b0;
            end else begin
                cpu_pend = 1'b0; cpu_req = 1'b0;
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
